// File: rtl/coherence_pkg.sv
// Shared types and field layout for the snooping-bus arbiter.
// Message layout: {type[8:7], tag[6:4], value[3:0]}.
package coherence_pkg;

  localparam int MSG_W    = 9;
  localparam int TAG_W    = 3;
  localparam int DATA_W   = 4;
  localparam int TYPE_LSB = 7;
  localparam int TAG_LSB  = 4;
  localparam int VAL_LSB  = 0;

  typedef enum logic [1:0] {
    MT_NONE       = 2'b00,
    MT_READ_MISS  = 2'b01,
    MT_READ_HIT   = 2'b10,
    MT_WRITE_BACK = 2'b11
  } msg_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BCAST,
    ST_SNOOP,
    ST_MEM,
    ST_DONE
  } state_e;

  // Every output is a register; the whole bank lives in one struct.
  typedef struct packed {
    state_e              state;
    logic [1:0]          gnt;
    logic                idx;
    logic                last;
    logic [MSG_W-1:0]    msg;
    logic [1:0]          done;
    logic                err;
    logic [DATA_W-1:0]   rsp;
    logic [DATA_W-1:0]   pend;
    logic                busy;
    logic                mem_req;
    logic                mem_we;
    logic [TAG_W-1:0]    mem_tag;
    logic [DATA_W-1:0]   mem_wdata;
    logic [7:0]          cnt;
  } arb_regs_t;

  function automatic msg_type_e msg_type(input logic [MSG_W-1:0] m);
    return msg_type_e'(m[MSG_W-1:TYPE_LSB]);
  endfunction

  function automatic logic [TAG_W-1:0] msg_tag(input logic [MSG_W-1:0] m);
    return m[TYPE_LSB-1:TAG_LSB];
  endfunction

  function automatic logic [DATA_W-1:0] msg_val(input logic [MSG_W-1:0] m);
    return m[TAG_LSB-1:VAL_LSB];
  endfunction

endpackage

// File: rtl/coherence_bus_arbiter_if.sv
// Signal bundle between the two cache controllers, main memory and the arbiter.
// The arbiter connects through 'slave'; the environment side uses 'master'.
interface coherence_bus_arbiter_if;
  import coherence_pkg::*;

  logic [1:0]        req;
  logic [MSG_W-1:0]  msg0;
  logic [MSG_W-1:0]  msg1;
  logic [1:0]        snoop_wb;
  logic [DATA_W-1:0] wb_data0;
  logic [DATA_W-1:0] wb_data1;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        gnt;
  logic [MSG_W-1:0]  bus_msg;
  logic [1:0]        done;
  logic [DATA_W-1:0] rsp_data;
  logic              err;
  logic              busy;
  logic              mem_req;
  logic              mem_we;
  logic [TAG_W-1:0]  mem_tag;
  logic [DATA_W-1:0] mem_wdata;

  modport slave (
    input  req, msg0, msg1, snoop_wb, wb_data0, wb_data1, mem_ack, mem_rdata,
    output gnt, bus_msg, done, rsp_data, err, busy, mem_req, mem_we, mem_tag, mem_wdata
  );

  modport master (
    output req, msg0, msg1, snoop_wb, wb_data0, wb_data1, mem_ack, mem_rdata,
    input  gnt, bus_msg, done, rsp_data, err, busy, mem_req, mem_we, mem_tag, mem_wdata
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: on a tie the requester that was not served last wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/coherence_bus_arbiter.sv
// Snooping-bus sequencer: round-robin grant, broadcast, snoop, optional memory
// access with timeout, then a one-cycle done pulse to the granted requester.
module coherence_bus_arbiter
  import coherence_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                    clock,
  input  logic                    resetn,
  coherence_bus_arbiter_if.slave  bus
);

  arb_regs_t         q, d;
  logic [1:0]        pick;
  logic              other_wb;
  logic [DATA_W-1:0] other_data;
  logic [7:0]        cnt_inc;

  rr_arbiter2 u_rr (
    .req  (bus.req),
    .last (q.last),
    .gnt  (pick)
  );

  // The snooper is always the requester that does not own the bus.
  assign other_wb   = q.idx ? bus.snoop_wb[0] : bus.snoop_wb[1];
  assign other_data = q.idx ? bus.wb_data0 : bus.wb_data1;
  assign cnt_inc    = q.cnt + 8'd1;

  always_comb begin
    // NOTE: start from the held value so every field has an assignment on every path; no latches.
    d = q;
    unique case (q.state)
      ST_IDLE: begin
        if (|pick) begin
          d.state = ST_BCAST;
          d.gnt   = pick;
          d.idx   = pick[1];
          d.msg   = pick[1] ? bus.msg1 : bus.msg0;
        end
      end
      ST_BCAST: begin
        if (msg_type(q.msg) == MT_NONE) begin
          d.state = ST_DONE;
          d.done  = q.gnt;
          d.rsp   = '0;
        end else begin
          d.state = ST_SNOOP;
        end
      end
      ST_SNOOP: begin
        d.mem_tag = msg_tag(q.msg);
        d.cnt     = '0;
        d.pend    = '0;
        unique case (msg_type(q.msg))
          MT_READ_MISS: begin
            d.state     = ST_MEM;
            d.mem_req   = 1'b1;
            d.mem_we    = other_wb;
            d.mem_wdata = other_wb ? other_data : '0;
            d.pend      = other_wb ? other_data : '0;
          end
          MT_WRITE_BACK: begin
            d.state     = ST_MEM;
            d.mem_req   = 1'b1;
            d.mem_we    = 1'b1;
            d.mem_wdata = msg_val(q.msg);
          end
          default: begin
            d.state   = ST_DONE;
            d.done    = q.gnt;
            d.rsp     = '0;
            d.mem_tag = '0;
          end
        endcase
      end
      ST_MEM: begin
        if (bus.mem_ack || cnt_inc == 8'(MEM_TIMEOUT)) begin
          d.state     = ST_DONE;
          d.done      = q.gnt;
          d.err       = !bus.mem_ack;
          d.rsp       = !bus.mem_ack ? '0 : (q.mem_we ? q.pend : bus.mem_rdata);
          d.mem_req   = 1'b0;
          d.mem_we    = 1'b0;
          d.mem_tag   = '0;
          d.mem_wdata = '0;
        end else begin
          d.cnt = cnt_inc;
        end
      end
      ST_DONE: begin
        d.state = ST_IDLE;
        d.last  = q.idx;
        d.gnt   = '0;
        d.msg   = '0;
        d.done  = '0;
        d.err   = 1'b0;
        d.rsp   = '0;
        d.pend  = '0;
      end
      default: d.state = ST_IDLE;
    endcase
    d.busy = (d.state != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    // NOTE: reset is synchronous and clears every register, aborting any transaction silently.
    if (!resetn) begin
      q      <= '0;
      q.last <= 1'b1;
    end else begin
      // NOTE: state registers use non-blocking assignment so all fields update together.
      q <= d;
    end
  end

  assign bus.gnt       = q.gnt;
  assign bus.bus_msg   = q.msg;
  assign bus.done      = q.done;
  assign bus.rsp_data  = q.rsp;
  assign bus.err       = q.err;
  assign bus.busy      = q.busy;
  assign bus.mem_req   = q.mem_req;
  assign bus.mem_we    = q.mem_we;
  assign bus.mem_tag   = q.mem_tag;
  assign bus.mem_wdata = q.mem_wdata;

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Directed bench for coherence_bus_arbiter: expected completions are queued as
// each request is issued and matched against every done pulse.
module tb_coherence_bus_arbiter;
  import coherence_pkg::*;

  typedef struct packed {
    logic [1:0] done;
    logic [3:0] rsp;
    logic       err;
  } exp_t;

  logic clock;
  logic resetn;
  int   tests;
  int   failed;
  exp_t sb[$];
  exp_t e;
  int   n;

  coherence_bus_arbiter_if bus ();

  coherence_bus_arbiter #(.MEM_TIMEOUT(15)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({bus.gnt, bus.bus_msg, bus.done, bus.rsp_data, bus.err, bus.busy,
                bus.mem_req, bus.mem_we, bus.mem_tag, bus.mem_wdata});
  endfunction

  // Called from the SNOOP cycle; counts MEM cycles, raising mem_ack in cycle ack_at (0 = never).
  task automatic mem_phase(input int ack_at, input logic [7:0] attr, output int cycles);
    cycles = 0;
    for (int c = 0; c < 64; c++) begin
      tick();
      if (bus.mem_req) begin
        cycles++;
        check("mem_attr", 32'({bus.mem_we, bus.mem_tag, bus.mem_wdata}), 32'(attr));
        if (cycles == ack_at) bus.mem_ack = 1'b1;
      end else if (cycles > 0) begin
        break;
      end
    end
    bus.mem_ack = 1'b0;
  endtask

  // Scoreboard and bus invariants, sampled mid-cycle.
  always @(negedge clock) begin
    check("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
    if (bus.done !== 2'b00) begin
      check("done_is_granted", 32'(bus.done & ~bus.gnt), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(bus.done), 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_done", 32'(bus.done), 32'(e.done));
        check("sb_rsp", 32'(bus.rsp_data), 32'(e.rsp));
        check("sb_err", 32'(bus.err), 32'(e.err));
      end
    end
  end

  initial begin
    tests  = 0;
    failed = 0;
    resetn = 1'b0;
    bus.req = '0;  bus.msg0 = '0;  bus.msg1 = '0;  bus.snoop_wb = '0;
    bus.wb_data0 = '0;  bus.wb_data1 = '0;  bus.mem_ack = 1'b0;  bus.mem_rdata = '0;
    repeat (3) tick();
    check("reset_outs", all_outs(), 32'd0);
    resetn = 1'b1;

    // Requester 0 ReadMiss tag 5, immediate ack, read data 9.
    bus.msg0 = 9'h0D0;  bus.mem_ack = 1'b1;  bus.mem_rdata = 4'd9;  bus.req = 2'b01;
    sb.push_back('{2'b01, 4'd9, 1'b0});
    tick();
    check("A_gnt", 32'(bus.gnt), 32'h1);
    check("A_bus_msg", 32'(bus.bus_msg), 32'h0D0);
    check("A_busy", 32'(bus.busy), 32'd1);
    tick();
    check("A_snoop_msg", 32'(bus.bus_msg), 32'h0D0);
    check("A_no_memreq_snoop", 32'(bus.mem_req), 32'd0);
    tick();
    check("A_mem", 32'({bus.mem_req, bus.mem_we, bus.mem_tag}), 32'({1'b1, 1'b0, 3'd5}));
    check("A_no_done_early", 32'(bus.done), 32'd0);
    tick();
    check("A_done_lat4", 32'(bus.done), 32'h1);
    check("A_rsp", 32'(bus.rsp_data), 32'd9);
    check("A_memreq_dropped", 32'(bus.mem_req), 32'd0);
    bus.req = 2'b00;
    tick();
    check("A_idle", 32'({bus.gnt, bus.bus_msg, bus.busy}), 32'd0);

    // Type NONE: straight BCAST -> DONE.
    bus.msg0 = 9'h035;  bus.req = 2'b01;
    sb.push_back('{2'b01, 4'd0, 1'b0});
    tick();
    check("N_gnt", 32'(bus.gnt), 32'h1);
    tick();
    check("N_done_lat2", 32'(bus.done), 32'h1);
    check("N_no_mem", 32'(bus.mem_req), 32'd0);
    bus.req = 2'b00;
    tick();

    // Fresh reset so the first tie goes to requester 0; continuous ReadHit contention.
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    bus.msg0 = 9'h113;  bus.msg1 = 9'h160;  bus.mem_ack = 1'b0;  bus.req = 2'b11;
    for (int i = 0; i < 4; i++) sb.push_back('{(i % 2 == 0) ? 2'b01 : 2'b10, 4'd0, 1'b0});
    for (int i = 0; i < 4; i++) begin
      logic [1:0] g;
      g = (i % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      check("B_gnt", 32'(bus.gnt), 32'(g));
      check("B_bus_msg", 32'(bus.bus_msg), (g == 2'b01) ? 32'h113 : 32'h160);
      tick();
      check("B_no_done_snoop", 32'(bus.done), 32'd0);
      tick();
      check("B_done_lat3", 32'(bus.done), 32'(g));
      check("B_no_mem", 32'(bus.mem_req), 32'd0);
      if (i == 3) bus.req = 2'b00;
      tick();
      check("B_idle_busy", 32'(bus.busy), 32'd0);
    end

    // Requester 1 ReadMiss tag 2, cache 0 dirty with 7 -> memory write of 7.
    bus.mem_ack = 1'b1;  bus.snoop_wb = 2'b01;  bus.wb_data0 = 4'd7;  bus.wb_data1 = 4'hA;
    bus.mem_rdata = 4'hF;  bus.msg1 = 9'h0A0;  bus.req = 2'b10;
    sb.push_back('{2'b10, 4'd7, 1'b0});
    tick();
    check("C_gnt", 32'(bus.gnt), 32'h2);
    tick();
    tick();
    check("C_mem_write", 32'({bus.mem_req, bus.mem_we, bus.mem_tag, bus.mem_wdata}),
          32'({1'b1, 1'b1, 3'd2, 4'd7}));
    tick();
    check("C_done", 32'(bus.done), 32'h2);
    check("C_rsp", 32'(bus.rsp_data), 32'd7);
    bus.req = 2'b00;
    tick();

    // Granted requester's own snoop bit is ignored: plain read.
    bus.snoop_wb = 2'b10;  bus.wb_data1 = 4'd5;  bus.mem_rdata = 4'hC;  bus.msg1 = 9'h0B0;
    bus.req = 2'b10;
    sb.push_back('{2'b10, 4'hC, 1'b0});
    repeat (3) tick();
    check("C2_mem_read", 32'({bus.mem_req, bus.mem_we, bus.mem_tag}), 32'({1'b1, 1'b0, 3'd3}));
    tick();
    check("C2_done", 32'(bus.done), 32'h2);
    check("C2_rsp", 32'(bus.rsp_data), 32'hC);
    bus.req = 2'b00;  bus.snoop_wb = 2'b00;
    tick();

    // Requester 0 WriteBack tag 4 value 6, ack in the 4th MEM cycle.
    bus.mem_ack = 1'b0;  bus.msg0 = 9'h1C6;  bus.req = 2'b01;
    sb.push_back('{2'b01, 4'd0, 1'b0});
    repeat (2) tick();
    mem_phase(4, {1'b1, 3'd4, 4'd6}, n);
    check("D_memreq_cycles", 32'(n), 32'd4);
    check("D_done", 32'(bus.done), 32'h1);
    check("D_err", 32'(bus.err), 32'd0);
    bus.req = 2'b00;
    tick();

    // No ack at all: timeout after 15 MEM cycles.
    bus.msg1 = 9'h0A0;  bus.mem_rdata = 4'hE;  bus.req = 2'b10;
    sb.push_back('{2'b10, 4'd0, 1'b1});
    repeat (2) tick();
    mem_phase(0, {1'b0, 3'd2, 4'd0}, n);
    check("E_memreq_cycles", 32'(n), 32'd15);
    check("E_done", 32'(bus.done), 32'h2);
    check("E_err", 32'(bus.err), 32'd1);
    check("E_rsp", 32'(bus.rsp_data), 32'd0);
    bus.req = 2'b00;
    tick();
    check("E_err_pulse", 32'(bus.err), 32'd0);

    // Normal service after the timeout.
    bus.msg0 = 9'h0F0;  bus.mem_rdata = 4'd3;  bus.req = 2'b01;
    sb.push_back('{2'b01, 4'd3, 1'b0});
    repeat (2) tick();
    mem_phase(1, {1'b0, 3'd7, 4'd0}, n);
    check("E2_memreq_cycles", 32'(n), 32'd1);
    check("E2_rsp", 32'(bus.rsp_data), 32'd3);
    bus.req = 2'b00;
    tick();

    // Reset in the middle of a memory access: no done, clean restart.
    bus.msg1 = 9'h199;  bus.req = 2'b10;
    repeat (3) tick();
    check("F_in_mem", 32'(bus.mem_req), 32'd1);
    tick();
    resetn = 1'b0;
    tick();
    check("F_reset_outs", all_outs(), 32'd0);
    resetn = 1'b1;
    bus.msg0 = 9'h113;  bus.msg1 = 9'h160;  bus.req = 2'b11;
    sb.push_back('{2'b01, 4'd0, 1'b0});
    tick();
    check("F_gnt_after_reset", 32'(bus.gnt), 32'h1);
    repeat (2) tick();
    check("F_done", 32'(bus.done), 32'h1);
    bus.req = 2'b00;
    repeat (3) tick();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/coherence_bus_arbiter.md
Name: coherence_bus_arbiter

Overview:
- Owns the shared snooping bus between the two cache controllers (proc1 = requester 0, proc2 = requester 1) and main memory.
- Grants the bus round-robin and broadcasts the granted 9-bit bus message.
- Sequences each transaction through broadcast, snoop, optional memory access and completion, replacing the free-running step counter as the bus sequencer.

Parameters:
- MSG_W, 9, bus message width: {type[8:7], tag[6:4], value[3:0]}
- TAG_W, 3, tag/address width
- DATA_W, 4, data value width
- MEM_TIMEOUT, 15, max cycles waiting for mem_ack before abort (1..255)

Ports:
- clock  in  1  system clock, rising edge
- resetn  in  1  synchronous active-low reset
- req  in  2  per-requester bus request; held until its done pulse
- msg0  in  9  requester 0 message, valid while req[0]
- msg1  in  9  requester 1 message, valid while req[1]
- snoop_wb  in  2  snooping cache holds tag dirty and will supply data (sampled in SNOOP)
- wb_data0  in  4  dirty data from cache 0
- wb_data1  in  4  dirty data from cache 1
- mem_ack  in  1  memory completed access (sampled in MEM)
- mem_rdata  in  4  memory read data, valid with mem_ack
- gnt  out  2  one-hot grant, held from BCAST through DONE
- bus_msg  out  9  broadcast message; 0 when idle
- done  out  2  one-cycle completion pulse to granted requester
- rsp_data  out  4  read result, valid with done
- err  out  1  one-cycle pulse with done on memory timeout
- busy  out  1  high in any state but IDLE
- mem_req  out  1  memory access request, held until ack/timeout
- mem_we  out  1  1 = write, 0 = read
- mem_tag  out  3  memory address
- mem_wdata  out  4  memory write data

Behaviour:
- Message types, bits [8:7]: 00 NONE, 01 ReadMiss, 10 ReadHit (write-hit invalidate broadcast), 11 WriteBack.
- Reset (resetn low at rising edge): state IDLE; all outputs 0; rr pointer last = 1, so requester 0 wins the first tie; timeout counter 0. Reset mid-transaction aborts it with no done or err.
- States: IDLE, BCAST, SNOOP, MEM, DONE. All outputs are registered.
- IDLE:
  - req sampled only here.
  - If exactly one req is set, grant it.
  - If both are set, grant the requester != last.
  - Latch its message.
  - A message with type NONE is granted but goes straight BCAST → DONE, with no memory access.
- BCAST: gnt and bus_msg driven for 1 cycle → SNOOP.
- SNOOP (1 cycle): bus_msg held. Sample snoop_wb of the non-granted requester only; the granted requester's bit is ignored.
  - ReadMiss with other snoop_wb = 1 → MEM as a write of the other cache's wb_data to the tag; rsp_data = that wb_data.
  - ReadMiss otherwise → MEM as a read of the tag.
  - WriteBack → MEM as a write of msg value to the tag.
  - ReadHit → DONE, rsp_data = 0.
- MEM:
  - mem_req = 1 with mem_we/mem_tag/mem_wdata stable.
  - On mem_ack → DONE. For a plain read, rsp_data = mem_rdata.
  - mem_ack may be asserted in the first MEM cycle.
  - Counter increments each MEM cycle without ack. When it reaches MEM_TIMEOUT → DONE with err = 1, rsp_data = 0.
  - mem_req drops when leaving MEM.
- DONE (1 cycle): done[g] = 1 and err as set. last = g; bus_msg = 0 next cycle → IDLE.
- Latency, measured from the IDLE cycle in which req is sampled:
  - ReadHit: done asserted in cycle +3.
  - Memory access with immediate ack: done in cycle +4.
- Back-to-back: a still-pending req from the other requester is granted in the IDLE cycle after DONE. Fairness: strict alternation under continuous contention.
- Dropping req mid-transaction is ignored; the transaction completes and done still pulses.
- gnt is never two-hot; done only ever targets the granted requester.

Decomposition:
- Shared package coherence_pkg: message-type constants (NONE/ReadMiss/ReadHit/WriteBack), field slice positions, MSG_W/TAG_W/DATA_W, state encoding.
- One natural sub-module: rr_arbiter2 (2-way round-robin pick from req and last; combinational, with a one-hot output).

Test Plan:
- Reset, then req = 01 with msg0 = {01,3'd5,4'd0}, mem_ack immediate, mem_rdata = 9 → gnt = 01, bus_msg = 0x0D0; mem_req with mem_we = 0, mem_tag = 5; done = 01 in cycle +4, rsp_data = 9.
- Both req high, both ReadHit, held continuously → grants 01, 10, 01, 10; each done 3 cycles after its IDLE; no memory access.
- Requester 1 ReadMiss tag 2 with snoop_wb = 01 and wb_data0 = 7 → memory write tag 2 data 7; done = 10, rsp_data = 7, no memory read.
- Requester 0 WriteBack {11,3'd4,4'd6} with mem_ack delayed 3 cycles → mem_req high 4 cycles, mem_we = 1, mem_wdata = 6; done = 01, err = 0.
- mem_ack never asserted, MEM_TIMEOUT = 15 → mem_req high exactly 15 cycles; done with err = 1, rsp_data = 0; next request is served normally.
- resetn low during MEM → all outputs 0 next cycle, no done; after release, a new req is granted to requester 0.
